// File: rtl/count_display_scanner_pkg.sv
// Shared definitions for the count display scanner.
// Holds the conversion FSM state type, the 7-segment font for decimal digits,
// the saturation limit and the digit count, plus a segment decode helper.
package count_display_scanner_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int MAX_DISP   = 9999;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } conv_state_t;

    // Segment order {g,f,e,d,c,b,a}, active high.
    localparam logic [6:0] SEG_FONT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    // Nibbles above 9 cannot come out of the converter; they decode dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        s = '0;
        if (nib <= 4'd9) begin
            s = SEG_FONT[nib];
        end
        return s;
    endfunction

endpackage

// File: rtl/count_display_scanner_bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Captures bin_in on start, saturating to MAX_DISP and flagging the overflow,
// then runs CNT_W shift iterations and pulses done for one cycle in COMMIT.
//
// Ports:
//   clk25, rst_n   clock, async active-low reset
//   start          capture request, honoured only in IDLE
//   bin_in         binary value to convert
//   busy           high from the cycle after start until the commit edge
//   done           high during COMMIT; consumer latches bcd/ovf_pending then
//   bcd            BCD result, digit 0 in bits [3:0]
//   ovf_pending    bin_in exceeded MAX_DISP at capture
//
// state  | meaning
// IDLE   | waiting for start
// CONV   | one double-dabble iteration per clock, CNT_W iterations
// COMMIT | result stable, done asserted for one cycle
module count_display_scanner_bin2bcd_seq
    import count_display_scanner_pkg::*;
#(
    parameter int CNT_W    = 14,
    parameter int MAX_DISP = 9999,
    parameter int BCD_W    = 16
) (
    input  logic             clk25,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd,
    output logic             ovf_pending
);

    localparam int               ITER_W    = $clog2(CNT_W);
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(CNT_W - 1);
    localparam logic [CNT_W-1:0]  MAX_VAL   = CNT_W'(MAX_DISP);

    conv_state_t       state, state_nxt;
    logic [CNT_W-1:0]  bin_sr, bin_nxt;
    logic [BCD_W-1:0]  bcd_acc, bcd_nxt, bcd_adj;
    logic [ITER_W-1:0] iter, iter_nxt;
    logic              ovf_pend, ovf_nxt;

    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] acc);
        logic [BCD_W-1:0] r;
        r = acc;
        for (int n = 0; n < BCD_W / 4; n++) begin
            if (acc[4*n +: 4] >= 4'd5) begin
                r[4*n +: 4] = acc[4*n +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bin_sr   <= '0;
            bcd_acc  <= '0;
            iter     <= '0;
            ovf_pend <= 1'b0;
        end else begin
            state    <= state_nxt;
            bin_sr   <= bin_nxt;
            bcd_acc  <= bcd_nxt;
            iter     <= iter_nxt;
            ovf_pend <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        bin_nxt   = bin_sr;
        bcd_nxt   = bcd_acc;
        iter_nxt  = iter;
        ovf_nxt   = ovf_pend;
        done      = 1'b0;
        bcd_adj   = dabble_adjust(bcd_acc);
        case (state)
            IDLE: begin
                if (start) begin
                    if (bin_in > MAX_VAL) begin
                        bin_nxt = MAX_VAL;
                        ovf_nxt = 1'b1;
                    end else begin
                        bin_nxt = bin_in;
                        ovf_nxt = 1'b0;
                    end
                    bcd_nxt   = '0;
                    iter_nxt  = '0;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                // Adjust, then shift {bcd,bin} left by one.
                bcd_nxt  = {bcd_adj[BCD_W-2:0], bin_sr[CNT_W-1]};
                bin_nxt  = {bin_sr[CNT_W-2:0], 1'b0};
                iter_nxt = iter + 1'b1;
                if (iter == LAST_ITER) begin
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy        = (state != IDLE);
    assign bcd         = bcd_acc;
    assign ovf_pending = ovf_pend;

endmodule

// File: rtl/count_display_scanner.sv
// Four-digit multiplexed 7-segment display for a 14-bit count snapshot.
// A load converts cnt_in to BCD in the background; the shown digits only
// change when a conversion commits. A free-running prescaler steps the
// active digit; seg and dig_sel are registered together so they always agree.
//
// Ports:
//   clk25    25 MHz system clock
//   rst_n    async active-low reset
//   cnt_in   count value to snapshot
//   load     single-cycle snapshot request (ignored while busy)
//   busy     conversion in progress
//   seg      segments {g,f,e,d,c,b,a}, active high
//   dp       decimal point, lit on all digits while ovf
//   dig_sel  one-hot digit enable, bit 0 = least significant digit
//   ovf      last snapshot exceeded MAX_DISP
module count_display_scanner
    import count_display_scanner_pkg::*;
#(
    parameter int CNT_W    = 14,
    parameter int DIGITS   = NUM_DIGITS,
    parameter int SCAN_DIV = 12,
    parameter int MAX_DISP = count_display_scanner_pkg::MAX_DISP
) (
    input  logic              clk25,
    input  logic              rst_n,
    input  logic [CNT_W-1:0]  cnt_in,
    input  logic              load,
    output logic              busy,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [DIGITS-1:0] dig_sel,
    output logic              ovf
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam int BCD_W = 4 * DIGITS;

    logic [SCAN_DIV-1:0] prescaler;
    logic [IDX_W-1:0]    dig_idx, idx_nxt;
    logic [BCD_W-1:0]    disp_bcd;
    logic [BCD_W-1:0]    conv_bcd;
    logic                conv_done, conv_ovf;
    logic [3:0]          nib;
    logic                blank;
    logic [6:0]          seg_nxt;
    logic [DIGITS-1:0]   dig_sel_nxt;

    count_display_scanner_bin2bcd_seq #(
        .CNT_W    (CNT_W),
        .MAX_DISP (MAX_DISP),
        .BCD_W    (BCD_W)
    ) u_bin2bcd (
        .clk25       (clk25),
        .rst_n       (rst_n),
        .start       (load),
        .bin_in      (cnt_in),
        .busy        (busy),
        .done        (conv_done),
        .bcd         (conv_bcd),
        .ovf_pending (conv_ovf)
    );

    // seg is computed for the digit that becomes active on this edge, so it
    // lands in the same cycle as the matching dig_sel.
    always_comb begin
        idx_nxt = dig_idx;
        if (&prescaler) begin
            idx_nxt = dig_idx + IDX_W'(1);
        end
        nib = disp_bcd[{idx_nxt, 2'b00} +: 4];
        // Leading zero: this digit and every digit above it are zero.
        blank = (idx_nxt != '0) && ((disp_bcd >> {idx_nxt, 2'b00}) == '0);
        seg_nxt = blank ? 7'h00 : seg_decode(nib);
        dig_sel_nxt = DIGITS'(1) << idx_nxt;
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            dig_idx   <= '0;
            dig_sel   <= DIGITS'(1);
            seg       <= '0;
            disp_bcd  <= '0;
            ovf       <= 1'b0;
        end else begin
            prescaler <= prescaler + 1'b1;
            dig_idx   <= idx_nxt;
            dig_sel   <= dig_sel_nxt;
            seg       <= seg_nxt;
            if (conv_done) begin
                disp_bcd <= conv_bcd;
                ovf      <= conv_ovf;
            end
        end
    end

    assign dp = ovf;

endmodule

// File: tb/tb_count_display_scanner.sv
module tb_count_display_scanner;

    localparam int SD    = 2;
    localparam int CW    = 14;
    localparam int LIMIT = 9999;

    logic          clk25 = 1'b0;
    logic          rst_n = 1'b1;
    logic          load  = 1'b0;
    logic [CW-1:0] cnt_in = '0;
    logic          busy;
    logic [6:0]    seg;
    logic          dp;
    logic [3:0]    dig_sel;
    logic          ovf;

    count_display_scanner #(
        .CNT_W    (CW),
        .DIGITS   (4),
        .SCAN_DIV (SD),
        .MAX_DISP (LIMIT)
    ) dut (
        .clk25   (clk25),
        .rst_n   (rst_n),
        .cnt_in  (cnt_in),
        .load    (load),
        .busy    (busy),
        .seg     (seg),
        .dp      (dp),
        .dig_sel (dig_sel),
        .ovf     (ovf)
    );

    always #20 clk25 = ~clk25;

    int tests = 0;
    int fails = 0;

    // Reference model state: edges since reset, remaining busy cycles,
    // shown value/overflow, value in flight, expected registered segments.
    int         k;
    int         busy_left;
    int         disp_val;
    bit         ovf_m;
    int         pend_val;
    bit         pend_ovf;
    logic [6:0] seg_exp;

    logic [6:0] font [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    function automatic logic [6:0] seg_of(int val, int idx);
        int p;
        p = 1;
        for (int i = 0; i < idx; i++) p = p * 10;
        if (idx > 0 && val < p) return 7'h00;
        return font[(val / p) % 10];
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h (k=%0d)", tag, obs, exp, k);
        end
    endtask

    task automatic check_outputs();
        int idx;
        idx = (k / (1 << SD)) % 4;
        check("dig_sel", 32'(dig_sel), 32'(4'b0001 << idx));
        check("seg",     32'(seg),     32'(seg_exp));
        check("dp",      32'(dp),      32'(ovf_m));
        check("busy",    32'(busy),    32'(busy_left > 0));
        check("ovf",     32'(ovf),     32'(ovf_m));
    endtask

    task automatic step();
        logic ld;
        int   cv;
        int   idx;
        ld = load;
        cv = int'(cnt_in);
        @(posedge clk25);
        k++;
        idx = (k / (1 << SD)) % 4;
        seg_exp = seg_of(disp_val, idx);
        if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
                disp_val = pend_val;
                ovf_m    = pend_ovf;
            end
        end else if (ld) begin
            pend_val  = (cv > LIMIT) ? LIMIT : cv;
            pend_ovf  = (cv > LIMIT);
            busy_left = 15;
        end
        @(negedge clk25);
        check_outputs();
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic do_load(int v);
        cnt_in = CW'(v);
        load   = 1'b1;
        step();
        load   = 1'b0;
        cnt_in = CW'($urandom_range(0, 16383));
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        k = 0; busy_left = 0; disp_val = 0; ovf_m = 1'b0; seg_exp = 7'h00;
        check_outputs();
        repeat (2) @(posedge clk25);
        @(negedge clk25);
        rst_n = 1'b1;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        int n;
        k = 0; busy_left = 0; disp_val = 0; ovf_m = 1'b0;
        pend_val = 0; pend_ovf = 1'b0; seg_exp = 7'h00;
        #5;
        apply_reset();
        run(20);

        do_load(1234);
        run(40);

        do_load(7);
        run(34);

        do_load(16383);
        run(34);
        do_load(42);
        run(34);

        do_load(9999);
        run(34);
        do_load(10000);
        run(34);
        do_load(0);
        run(34);

        do_load(305);
        run(3);
        do_load(999);
        run(40);

        do_load(8888);
        run(5);
        apply_reset();
        run(20);
        do_load(10);
        run(34);

        for (int r = 0; r < 30; r++) begin
            v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 120))
                                            : int'($urandom_range(0, 16383));
            do_load(v);
            n = $urandom_range(0, 36);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 9) == 0) begin
                    load   = 1'b1;
                    cnt_in = CW'($urandom_range(0, 16383));
                end
                step();
                load = 1'b0;
            end
        end
        run(40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
